// File: rtl/branch_recovery_ctrl.sv
// Branch recovery sequencer: picks the oldest mispredict across resolution ports and
// runs checkpoint restore -> flush -> fetch redirect, stalling dispatch throughout.
module branch_recovery_ctrl #(
  parameter int ROB_WIDTH    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int PC_WIDTH     = 32,
  parameter int NUM_PORTS    = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           i_br_valid,
  input  logic [NUM_PORTS-1:0]           i_br_mispredict,
  input  logic [NUM_PORTS*ROB_WIDTH-1:0] i_br_tag,
  input  logic [NUM_PORTS*PC_WIDTH-1:0]  i_br_target,
  input  logic [ROB_WIDTH-1:0]           i_rob_head,
  output logic                           o_restore,
  output logic [ROB_WIDTH-1:0]           o_restore_tag,
  input  logic [DATA_WIDTH-1:0]          i_restore_data,
  output logic                           o_restored_valid,
  output logic [DATA_WIDTH-1:0]          o_restored_state,
  output logic                           o_flush,
  output logic [ROB_WIDTH-1:0]           o_flush_tag,
  output logic                           o_redirect_valid,
  output logic [PC_WIDTH-1:0]            o_redirect_pc,
  output logic                           o_stall_dispatch
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("branch_recovery_ctrl: FLUSH_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RESTORE, FLUSH, REDIRECT} state_t;

  state_t                state;
  logic [ROB_WIDTH-1:0]  pend_tag;
  logic [PC_WIDTH-1:0]   pend_pc;
  logic [CW-1:0]         flush_cnt;
  logic                  restored_valid_q;
  logic [DATA_WIDTH-1:0] restored_state_q;

  logic                  cand_found;
  logic [ROB_WIDTH-1:0]  cand_tag;
  logic [ROB_WIDTH-1:0]  cand_age;
  logic [PC_WIDTH-1:0]   cand_pc;
  logic [ROB_WIDTH-1:0]  port_tag;
  logic [ROB_WIDTH-1:0]  port_age;
  logic [ROB_WIDTH-1:0]  pend_age;
  logic                  preempt;

  // Oldest mispredict this cycle; strict compare keeps the lower port on equal age.
  always_comb begin
    cand_found = 1'b0;
    cand_tag   = '0;
    cand_age   = '0;
    cand_pc    = '0;
    port_tag   = '0;
    port_age   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_tag = i_br_tag[p*ROB_WIDTH +: ROB_WIDTH];
      port_age = port_tag - i_rob_head;
      if (i_br_valid[p] && i_br_mispredict[p]) begin
        if (!cand_found || (port_age < cand_age)) begin
          cand_found = 1'b1;
          cand_tag   = port_tag;
          cand_age   = port_age;
          cand_pc    = i_br_target[p*PC_WIDTH +: PC_WIDTH];
        end
      end
    end
  end

  assign pend_age = pend_tag - i_rob_head;
  assign preempt  = cand_found && (cand_age < pend_age);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      pend_tag         <= '0;
      pend_pc          <= '0;
      flush_cnt        <= '0;
      restored_valid_q <= 1'b0;
      restored_state_q <= '0;
    end else begin
      restored_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cand_found) begin
            pend_tag <= cand_tag;
            pend_pc  <= cand_pc;
            state    <= RESTORE;
          end
        end
        RESTORE: begin
          restored_state_q <= i_restore_data;
          if (preempt) begin
            pend_tag  <= cand_tag;
            pend_pc   <= cand_pc;
            flush_cnt <= '0;
            state     <= RESTORE;
          end else begin
            restored_valid_q <= 1'b1;
            flush_cnt        <= CW'(FLUSH_CYCLES - 1);
            state            <= FLUSH;
          end
        end
        FLUSH: begin
          // An older mispredict here also cancels the redirect the last flush cycle would lead to.
          if (preempt) begin
            pend_tag  <= cand_tag;
            pend_pc   <= cand_pc;
            flush_cnt <= '0;
            state     <= RESTORE;
          end else if (flush_cnt == '0) begin
            state <= REDIRECT;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        REDIRECT: begin
          // Leaving REDIRECT behaves like IDLE: any new mispredict starts a fresh recovery.
          if (cand_found) begin
            pend_tag <= cand_tag;
            pend_pc  <= cand_pc;
            state    <= RESTORE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_restore        = (state == RESTORE);
  assign o_restore_tag    = (state == RESTORE) ? pend_tag : '0;
  assign o_restored_valid = restored_valid_q;
  assign o_restored_state = restored_state_q;
  assign o_flush          = (state == FLUSH);
  assign o_flush_tag      = (state == FLUSH) ? pend_tag : '0;
  assign o_redirect_valid = (state == REDIRECT);
  assign o_redirect_pc    = (state == REDIRECT) ? pend_pc : '0;
  assign o_stall_dispatch = (state != IDLE);

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed bench for branch_recovery_ctrl: vector table for single recoveries plus
// hand sequences for preemption, younger mispredicts and mid-sequence reset.
module tb_branch_recovery_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  br_valid;
  logic [1:0]  br_mispredict;
  logic [7:0]  br_tag;
  logic [63:0] br_target;
  logic [3:0]  rob_head;
  logic        restore;
  logic [3:0]  restore_tag;
  logic [31:0] restore_data;
  logic        restored_valid;
  logic [31:0] restored_state;
  logic        flush;
  logic [3:0]  flush_tag;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_dispatch;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_recovery_ctrl #(
    .ROB_WIDTH(4), .DATA_WIDTH(32), .PC_WIDTH(32), .NUM_PORTS(2), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_br_valid(br_valid),
    .i_br_mispredict(br_mispredict),
    .i_br_tag(br_tag),
    .i_br_target(br_target),
    .i_rob_head(rob_head),
    .o_restore(restore),
    .o_restore_tag(restore_tag),
    .i_restore_data(restore_data),
    .o_restored_valid(restored_valid),
    .o_restored_state(restored_state),
    .o_flush(flush),
    .o_flush_tag(flush_tag),
    .o_redirect_valid(redirect_valid),
    .o_redirect_pc(redirect_pc),
    .o_stall_dispatch(stall_dispatch)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  mp;
    logic [3:0]  tag0;
    logic [3:0]  tag1;
    logic [31:0] tgt0;
    logic [31:0] tgt1;
    logic [3:0]  head;
    logic [31:0] data;
    logic        act;
    logic [3:0]  exp_tag;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_br();
    br_valid      = 2'b00;
    br_mispredict = 2'b00;
    br_tag        = '0;
    br_target     = '0;
  endtask

  task automatic drive_one(input logic [3:0] tag, input logic [31:0] tgt);
    br_valid      = 2'b01;
    br_mispredict = 2'b01;
    br_tag        = {4'd0, tag};
    br_target     = {32'd0, tgt};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_restore"},        restore, 0);
    chk({tag, "_restore_tag"},    restore_tag, 0);
    chk({tag, "_restored_valid"}, restored_valid, 0);
    chk({tag, "_restored_state"}, restored_state, 0);
    chk({tag, "_flush"},          flush, 0);
    chk({tag, "_flush_tag"},      flush_tag, 0);
    chk({tag, "_redirect_valid"}, redirect_valid, 0);
    chk({tag, "_redirect_pc"},    redirect_pc, 0);
    chk({tag, "_stall"},          stall_dispatch, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string n;
    n             = $sformatf("v%0d", idx);
    br_valid      = v.valid;
    br_mispredict = v.mp;
    br_tag        = {v.tag1, v.tag0};
    br_target     = {v.tgt1, v.tgt0};
    rob_head      = v.head;
    restore_data  = v.data;
    tick();
    clear_br();
    if (!v.act) begin
      for (int i = 0; i < 4; i++) begin
        chk({n, "_quiet_stall"},    stall_dispatch, 0);
        chk({n, "_quiet_restore"},  restore, 0);
        chk({n, "_quiet_flush"},    flush, 0);
        chk({n, "_quiet_redirect"}, redirect_valid, 0);
        tick();
      end
    end else begin
      chk({n, "_t1_restore"},     restore, 1);
      chk({n, "_t1_restore_tag"}, restore_tag, v.exp_tag);
      chk({n, "_t1_stall"},       stall_dispatch, 1);
      chk({n, "_t1_flush"},       flush, 0);
      tick();
      chk({n, "_t2_rvalid"},      restored_valid, 1);
      chk({n, "_t2_rstate"},      restored_state, v.data);
      chk({n, "_t2_flush"},       flush, 1);
      chk({n, "_t2_flush_tag"},   flush_tag, v.exp_tag);
      chk({n, "_t2_restore"},     restore, 0);
      tick();
      chk({n, "_t3_flush"},       flush, 1);
      chk({n, "_t3_rvalid"},      restored_valid, 0);
      chk({n, "_t3_redirect"},    redirect_valid, 0);
      tick();
      chk({n, "_t4_redirect"},    redirect_valid, 1);
      chk({n, "_t4_pc"},          redirect_pc, v.exp_pc);
      chk({n, "_t4_flush"},       flush, 0);
      chk({n, "_t4_stall"},       stall_dispatch, 1);
      tick();
      chk({n, "_t5_stall"},       stall_dispatch, 0);
      chk({n, "_t5_redirect"},    redirect_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // valid, mp, tag0, tag1, tgt0, tgt1, head, data, act, exp_tag, exp_pc
    vecs[0] = '{2'b01, 2'b01, 4'd5, 4'd0,  32'h100, 32'h0,   4'd2,  32'hABCD, 1'b1, 4'd5,  32'h100};
    vecs[1] = '{2'b11, 2'b11, 4'd1, 4'd15, 32'h111, 32'h222, 4'd14, 32'h1234, 1'b1, 4'd15, 32'h222};
    vecs[2] = '{2'b11, 2'b00, 4'd3, 4'd4,  32'h333, 32'h444, 4'd0,  32'h5555, 1'b0, 4'd0,  32'h0};
    vecs[3] = '{2'b11, 2'b11, 4'd3, 4'd3,  32'h333, 32'h444, 4'd0,  32'h7777, 1'b1, 4'd3,  32'h333};
    vecs[4] = '{2'b11, 2'b10, 4'd1, 4'd6,  32'h111, 32'h600, 4'd0,  32'h8888, 1'b1, 4'd6,  32'h600};
    vecs[5] = '{2'b11, 2'b11, 4'd7, 4'd9,  32'h777, 32'h999, 4'd8,  32'h9999, 1'b1, 4'd9,  32'h999};

    reset        = 1'b1;
    clear_br();
    rob_head     = '0;
    restore_data = '0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("post_reset");

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Older mispredict during the first flush cycle restarts recovery on tag 7.
    rob_head     = 4'd6;
    restore_data = 32'h0F0F;
    drive_one(4'd9, 32'h900);
    tick();
    clear_br();
    chk("pre_t1_restore_tag", restore_tag, 9);
    tick();
    chk("pre_t2_flush", flush, 1);
    drive_one(4'd7, 32'h200);
    tick();
    clear_br();
    chk("pre_t3_restore",     restore, 1);
    chk("pre_t3_restore_tag", restore_tag, 7);
    chk("pre_t3_flush",       flush, 0);
    tick();
    chk("pre_t4_redirect",    redirect_valid, 0);
    chk("pre_t4_flush_tag",   flush_tag, 7);
    chk("pre_t4_rvalid",      restored_valid, 1);
    tick();
    chk("pre_t5_redirect",    redirect_valid, 0);
    chk("pre_t5_flush",       flush, 1);
    tick();
    chk("pre_t6_redirect",    redirect_valid, 1);
    chk("pre_t6_pc",          redirect_pc, 32'h200);
    tick();
    chk("pre_t7_redirect",    redirect_valid, 0);
    chk("pre_t7_stall",       stall_dispatch, 0);

    // Younger mispredict during flush is dropped; timing stays as for tag 7 alone.
    drive_one(4'd7, 32'h700);
    tick();
    clear_br();
    chk("yng_t1_restore_tag", restore_tag, 7);
    tick();
    drive_one(4'd9, 32'h999);
    tick();
    clear_br();
    chk("yng_t3_restore",     restore, 0);
    chk("yng_t3_flush",       flush, 1);
    chk("yng_t3_flush_tag",   flush_tag, 7);
    tick();
    chk("yng_t4_redirect",    redirect_valid, 1);
    chk("yng_t4_pc",          redirect_pc, 32'h700);
    tick();
    chk("yng_t5_stall",       stall_dispatch, 0);
    chk("yng_t5_restore",     restore, 0);

    // Reset in the second flush cycle aborts without a redirect.
    rob_head = 4'd2;
    drive_one(4'd5, 32'h100);
    tick();
    clear_br();
    tick();
    chk("rst_t2_flush", flush, 1);
    tick();
    chk("rst_t3_flush", flush, 1);
    reset = 1'b1;
    tick();
    chk_all_zero("rst_abort");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_after_redirect", redirect_valid, 0);
      chk("rst_after_stall",    stall_dispatch, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
